// File: rtl/rf_wb_pkg.sv
// Shared types and default widths for the register-file writeback controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_wb_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int AW_DEFAULT    = 5;
   localparam int DEPTH_DEFAULT = 4;

   // One queued register write.
   typedef struct packed {
      logic [AW_DEFAULT-1:0]   rd;
      logic [XLEN_DEFAULT-1:0] data;
   } rf_wb_entry_t;

   // Result source; also the record of which source won the last conflict.
   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSU = 1'b1
   } rf_wb_src_e;

endpackage

// File: rtl/rf_wb_if.sv
// Bundle of result handshakes, RegFile write/read port signals and status.
// Latency: n/a (wires only).
// Backpressure: alu_ready/lsu_ready are driven by the slave (controller).
// Ports: master = producers/RegFile side, slave = rf_wb_ctrl.
interface rf_wb_if #(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            alu_valid;
   logic            alu_ready;
   logic [AW-1:0]   alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [AW-1:0]   lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            wr_hold;
   logic [AW-1:0]   io_rf_wa;
   logic            io_rf_wen;
   logic [XLEN-1:0] io_rf_wd;
   logic [AW-1:0]   io_rf_ra1;
   logic [AW-1:0]   io_rf_ra2;
   logic [AW-1:0]   ra1;
   logic [AW-1:0]   ra2;
   logic [XLEN-1:0] rf_rd1;
   logic [XLEN-1:0] rf_rd2;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic [CW-1:0]   pending;
   logic            empty;

   modport slave (
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             wr_hold, ra1, ra2, rf_rd1, rf_rd2,
      output alu_ready, lsu_ready, io_rf_wa, io_rf_wen, io_rf_wd,
             io_rf_ra1, io_rf_ra2, rd1, rd2, pending, empty
   );

   modport master (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             wr_hold, ra1, ra2, rf_rd1, rf_rd2,
      input  alu_ready, lsu_ready, io_rf_wa, io_rf_wen, io_rf_wd,
             io_rf_ra1, io_rf_ra2, rd1, rd2, pending, empty
   );
endinterface

// File: rtl/rf_wb_fifo.sv
// In-order write queue: storage, head/tail pointers, count, per-slot valid.
// Latency: pushed entry visible at head one cycle after the push edge.
// Backpressure: none internally; caller must not push when full or pop when empty.
// Ports: push/push_rd/push_data, pop, head_rd/head_data, count, plus raw
//        slot contents, valid vector and head pointer for the bypass match.
module rf_wb_fifo #(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 4,
   parameter int PTRW  = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [AW-1:0]              push_rd,
   input  logic [XLEN-1:0]            push_data,
   input  logic                       pop,
   output logic [AW-1:0]              head_rd,
   output logic [XLEN-1:0]            head_data,
   output logic [CW-1:0]              count,
   output logic [DEPTH-1:0]           valid,
   output logic [PTRW-1:0]            head_ptr,
   output logic [DEPTH-1:0][AW-1:0]   slot_rd,
   output logic [DEPTH-1:0][XLEN-1:0] slot_data
);
   logic [PTRW-1:0]            head_q, head_d;
   logic [PTRW-1:0]            tail_q, tail_d;
   logic [CW-1:0]              count_q, count_d;
   logic [DEPTH-1:0]           valid_q, valid_d;
   logic [DEPTH-1:0][AW-1:0]   rd_mem_q, rd_mem_d;
   logic [DEPTH-1:0][XLEN-1:0] data_mem_q, data_mem_d;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      valid_d    = valid_q;
      rd_mem_d   = rd_mem_q;
      data_mem_d = data_mem_q;
      if (push) begin
         rd_mem_d[tail_q]   = push_rd;
         data_mem_d[tail_q] = push_data;
         valid_d[tail_q]    = 1'b1;
         tail_d             = tail_q + 1'b1;   // DEPTH is a power of two: natural wrap
      end
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         valid_q    <= '0;
         rd_mem_q   <= '0;
         data_mem_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         rd_mem_q   <= rd_mem_d;
         data_mem_q <= data_mem_d;
      end
   end

   assign head_rd   = rd_mem_q[head_q];
   assign head_data = data_mem_q[head_q];
   assign count     = count_q;
   assign valid     = valid_q;
   assign head_ptr  = head_q;
   assign slot_rd   = rd_mem_q;
   assign slot_data = data_mem_q;
endmodule

// File: rtl/rf_wb_ctrl.sv
// Writeback controller: round-robin ALU/LSU results into a FIFO draining to RegFile.
// Latency: accepted at edge N, written at edge N+1 when queue empty and no wr_hold.
// Backpressure: *_ready low when full or losing arbitration; wr_hold stalls draining.
// Ports: clk, reset_n, bus (rf_wb_if.slave) carrying handshakes, RegFile port, status.
// Build option: define RF_WB_BYPASS_EN to forward queued data onto rd1/rd2.
module rf_wb_ctrl
   import rf_wb_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int AW    = AW_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic  clk,
   input  logic  reset_n,
   rf_wb_if.slave bus
);
   localparam int PTRW = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH) + 1;

   rf_wb_src_e                 last_grant_q, last_grant_d;
   logic                       full, conflict, alu_win, lsu_win;
   logic                       alu_rdy, lsu_rdy, alu_fire, lsu_fire;
   logic                       push, pop;
   logic [AW-1:0]              push_rd;
   logic [XLEN-1:0]            push_data;
   logic [AW-1:0]              head_rd;
   logic [XLEN-1:0]            head_data;
   logic [CW-1:0]              fifo_count;
   logic [DEPTH-1:0]           fifo_valid;
   logic [PTRW-1:0]            head_ptr;
   logic [DEPTH-1:0][AW-1:0]   slot_rd;
   logic [DEPTH-1:0][XLEN-1:0] slot_data;
   logic [XLEN-1:0]            fwd1, fwd2;

   rf_wb_fifo #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_rd   (push_rd),
      .push_data (push_data),
      .pop       (pop),
      .head_rd   (head_rd),
      .head_data (head_data),
      .count     (fifo_count),
      .valid     (fifo_valid),
      .head_ptr  (head_ptr),
      .slot_rd   (slot_rd),
      .slot_data (slot_data)
   );

   always_comb begin
      // A same-cycle pop never frees a slot for a push: full uses the registered count.
      full     = (fifo_count == CW'(DEPTH));
      conflict = bus.alu_valid && bus.lsu_valid;
      // Ready depends only on the other source's valid, so no valid->ready loop.
      alu_win  = !bus.lsu_valid || (last_grant_q == SRC_LSU);
      lsu_win  = !bus.alu_valid || (last_grant_q == SRC_ALU);
      alu_rdy  = reset_n && !full && alu_win;
      lsu_rdy  = reset_n && !full && lsu_win;
      alu_fire = bus.alu_valid && alu_rdy;
      lsu_fire = bus.lsu_valid && lsu_rdy;

      push      = 1'b0;
      push_rd   = bus.alu_rd;
      push_data = bus.alu_data;
      if (alu_fire) begin
         push = (bus.alu_rd != '0);   // x0 writes complete the handshake but are dropped
      end else if (lsu_fire) begin
         push      = (bus.lsu_rd != '0);
         push_rd   = bus.lsu_rd;
         push_data = bus.lsu_data;
      end

      pop = (fifo_count != '0) && !bus.wr_hold;

      last_grant_d = last_grant_q;
      if (conflict && !full) begin
         last_grant_d = alu_fire ? SRC_ALU : SRC_LSU;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= SRC_ALU;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

`ifdef RF_WB_BYPASS_EN
   logic [PTRW-1:0] slot;

   // Walk from oldest to youngest so the youngest matching entry wins.
   always_comb begin
      fwd1 = bus.rf_rd1;
      fwd2 = bus.rf_rd2;
      slot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot = head_ptr + PTRW'(i);
         if (fifo_valid[slot] && (bus.ra1 != '0) && (slot_rd[slot] == bus.ra1)) begin
            fwd1 = slot_data[slot];
         end
         if (fifo_valid[slot] && (bus.ra2 != '0) && (slot_rd[slot] == bus.ra2)) begin
            fwd2 = slot_data[slot];
         end
      end
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{fifo_valid, head_ptr, slot_rd, slot_data};
   assign fwd1 = bus.rf_rd1;
   assign fwd2 = bus.rf_rd2;
`endif

   assign bus.alu_ready = alu_rdy;
   assign bus.lsu_ready = lsu_rdy;
   assign bus.io_rf_wen = pop;
   assign bus.io_rf_wa  = (fifo_count != '0) ? head_rd   : '0;
   assign bus.io_rf_wd  = (fifo_count != '0) ? head_data : '0;
   assign bus.io_rf_ra1 = bus.ra1;
   assign bus.io_rf_ra2 = bus.ra2;
   assign bus.rd1       = fwd1;
   assign bus.rd2       = fwd2;
   assign bus.pending   = fifo_count;
   assign bus.empty     = (fifo_count == '0);
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed scenarios then random traffic vs a queue model.
// Latency: n/a.
// Backpressure: model predicts readies; producers drop valid only on their own schedule.
module tb_rf_wb_ctrl;
   import rf_wb_pkg::*;

   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   rf_wb_if #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) bus ();

   rf_wb_ctrl #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // Model: queue of pending writes, oldest at index 0, plus who won the last conflict.
   rf_wb_entry_t q[$];
   bit           lsu_won_last = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] adat,
                        input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ldat,
                        input logic hold);
      bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = adat;
      bus.lsu_valid = lv;  bus.lsu_rd = lrd;  bus.lsu_data = ldat;
      bus.wr_hold   = hold;
   endtask

   task automatic fwd_exp(input logic [AW-1:0] ra, input logic [XLEN-1:0] raw,
                          output logic [XLEN-1:0] e);
      e = raw;
`ifdef RF_WB_BYPASS_EN
      if (ra != 0) begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].rd == ra) begin
               e = q[i].data;
               break;
            end
         end
      end
`endif
   endtask

   // Called one time unit after a rising edge with inputs already applied.
   task automatic cycle();
      logic            ear, elr, ewen, fa, fl;
      logic [AW-1:0]   ewa;
      logic [XLEN-1:0] ewd, e1, e2;
      int              sz;
      #2;
      if (!reset_n) begin
         q.delete();
         lsu_won_last = 1'b0;
      end
      ear = reset_n && (q.size() < DEPTH) && (!bus.lsu_valid || lsu_won_last);
      elr = reset_n && (q.size() < DEPTH) && (!bus.alu_valid || !lsu_won_last);
      ewen = (q.size() != 0) && !bus.wr_hold;
      ewa  = (q.size() != 0) ? q[0].rd   : '0;
      ewd  = (q.size() != 0) ? q[0].data : '0;
      fwd_exp(bus.ra1, bus.rf_rd1, e1);
      fwd_exp(bus.ra2, bus.rf_rd2, e2);
      chk("alu_ready", 64'(bus.alu_ready), 64'(ear));
      chk("lsu_ready", 64'(bus.lsu_ready), 64'(elr));
      chk("io_rf_wen", 64'(bus.io_rf_wen), 64'(ewen));
      chk("io_rf_wa",  64'(bus.io_rf_wa),  64'(ewa));
      chk("io_rf_wd",  64'(bus.io_rf_wd),  64'(ewd));
      chk("pending",   64'(bus.pending),   64'(q.size()));
      chk("empty",     64'(bus.empty),     64'(q.size() == 0));
      chk("rd1",       64'(bus.rd1),       64'(e1));
      chk("rd2",       64'(bus.rd2),       64'(e2));
      fa = bus.alu_valid && ear;
      fl = bus.lsu_valid && elr;
      @(posedge clk);
      if (reset_n) begin
         sz = q.size();
         if (ewen) void'(q.pop_front());
         if (fa && bus.alu_rd != 0)      q.push_back('{rd: bus.alu_rd, data: bus.alu_data});
         else if (fl && bus.lsu_rd != 0) q.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
         if (bus.alu_valid && bus.lsu_valid && sz < DEPTH) lsu_won_last = fl;
      end
      #1;
   endtask

   task automatic idle(input logic hold, input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, '0, '0, 1'b0, '0, '0, hold);
         cycle();
      end
   endtask

   initial begin
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      bus.ra1 = '0;  bus.ra2 = '0;
      bus.rf_rd1 = 32'hA5A5_0001;  bus.rf_rd2 = 32'h5A5A_0002;

      // Reset state
      @(posedge clk); #1;
      cycle();
      reset_n = 1'b1;
      idle(1'b0, 1);

      // Single write: rd=5 0xDEADBEEF, written the next cycle
      drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0);
      cycle();
      idle(1'b0, 2);

      // Conflict round-robin: LSU, ALU, LSU
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200 + i, 1'b0);
         cycle();
      end
      idle(1'b0, 3);

      // Fill under hold, attempt a fifth push, then release
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 5'(i), 32'hF000 + i, 1'b0, '0, '0, 1'b1);
         cycle();
      end
      drive(1'b1, 5'd9, 32'hBAD, 1'b0, '0, '0, 1'b1);
      cycle();
      idle(1'b0, 5);

      // Bypass: two writes to r7 held in the queue
      drive(1'b1, 5'd7, 32'h11, 1'b0, '0, '0, 1'b1);
      cycle();
      drive(1'b1, 5'd7, 32'h22, 1'b0, '0, '0, 1'b1);
      cycle();
      bus.ra1 = 5'd7;  bus.rf_rd1 = 32'h0;
      bus.ra2 = 5'd8;  bus.rf_rd2 = 32'h5555_5555;
      idle(1'b1, 2);
      bus.ra2 = 5'd0;
      idle(1'b1, 1);
      idle(1'b0, 3);

      // x0 discard
      drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, 1'b0);
      cycle();
      idle(1'b0, 2);

      // Reset with three entries queued
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'(3 + i), 32'hC0 + i, 1'b0, '0, '0, 1'b1);
         cycle();
      end
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      reset_n = 1'b0;
      cycle();
      cycle();
      reset_n = 1'b1;
      idle(1'b0, 3);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 9) < 3));
         bus.ra1 = 5'($urandom_range(0, 7));
         bus.ra2 = 5'($urandom_range(0, 7));
         bus.rf_rd1 = $urandom;
         bus.rf_rd2 = $urandom;
         cycle();
      end
      idle(1'b0, 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Writeback controller that drives the write port of `RegFile` and forwards pending results onto its read ports. It accepts results from the ALU and the load/store unit over valid/ready, arbitrates them round-robin, and queues them in a small in-order FIFO. It drains one entry per cycle onto `io_rf_wa`/`io_rf_wen`/`io_rf_wd`, and bypasses queued data to readers so a queued write is never seen stale. It sits between the execute/memory stages and `RegFile` in the core.

## Interface
Parameters:
- `XLEN`, 32, data width
- `AW`, 5, register address width
- `DEPTH`, 4, FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  core clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `alu_valid` / `alu_ready`  in / out  1 / 1  ALU result handshake
- `alu_rd`, `alu_data`  in  AW, XLEN  ALU destination and value
- `lsu_valid` / `lsu_ready`  in / out  1 / 1  load result handshake
- `lsu_rd`, `lsu_data`  in  AW, XLEN  load destination and value
- `wr_hold`  in  1  suspend draining; write port is borrowed by debug
- `io_rf_wa`  out  AW  RegFile write address
- `io_rf_wen`  out  1  RegFile write enable
- `io_rf_wd`  out  XLEN  RegFile write data
- `ra1`, `ra2`  in  AW  reader addresses, also wired to `io_rf_ra1`/`io_rf_ra2`
- `rf_rd1`, `rf_rd2`  in  XLEN  raw RegFile read data
- `rd1`, `rd2`  out  XLEN  forwarded read data
- `pending`  out  $clog2(DEPTH)+1  occupied entries
- `empty`  out  1  `pending == 0`

## Operation
- **Ready.** `alu_ready` and `lsu_ready` are high only when `pending < DEPTH` and that source wins arbitration. Full blocks both sources. A same-cycle dequeue does not free a slot for an enqueue in that cycle.
- **Arbitration.** With a single valid source, that source wins. With both valid, the source not granted last time wins.
  - `last_grant` updates only on a conflict.
  - `last_grant` resets to ALU, so the first conflict goes to the LSU.
- **Enqueue.** A handshake (`valid && ready`) with `rd != 0` pushes {rd, data} at the tail.
  - `rd == 0` still completes the handshake but is discarded: no push, `pending` unchanged.
- **Drain.** When `pending != 0 && !wr_hold`:
  - `io_rf_wen = 1`, `io_rf_wa`/`io_rf_wd` equal the head entry.
  - The head pops at the clock edge.
  - Otherwise `io_rf_wen = 0`; `io_rf_wa`/`io_rf_wd` still show the head, or 0 when empty.
- **Simultaneous push and pop.** Both occur; `pending` is unchanged.
- **Pointer wrap.** Head and tail pointers wrap modulo `DEPTH`.
- **Bypass.** `rd1` is the data of the youngest valid entry (head entry included) whose rd equals `ra1`; otherwise `rd1 = rf_rd1`. `rd2` is the same using `ra2`/`rf_rd2`.
  - `ra == 0` always returns `rf_rdN`.
  - Entries accepted this cycle are not forwarded.
- **Reset.** Asserting `reset_n` low mid-operation discards all queued entries with no writes. While in reset:
  - `pending = 0`, `empty = 1`.
  - `io_rf_wen = 0`, `io_rf_wa = 0`, `io_rf_wd = 0`.
  - `alu_ready = lsu_ready = 0`.
  - `rd1`/`rd2` follow `rf_rd1`/`rf_rd2`.

## Timing
- **Write latency.** A result accepted at edge N is written into RegFile at edge N+1 (`io_rf_wen` high during cycle N→N+1), given an empty FIFO and `wr_hold` low.
- **Throughput.** One push and one pop per cycle. The FIFO fills only under `wr_hold`.
- **Port outputs.** `io_rf_*` depend only on registered state and `wr_hold`, never on `*_valid`.
- **Bypass path.** `rd1`/`rd2` are combinational from `ra*`, `rf_rd*` and FIFO state.
- **Ready path.** `*_ready` are combinational from `pending`, the other source's valid, and `last_grant`.

## Configuration
- **`RF_WB_BYPASS_EN` defined.** Forwarding is built as described above.
- **`RF_WB_BYPASS_EN` undefined.** Comparators are removed and `rd1 = rf_rd1`, `rd2 = rf_rd2`. Consumers must instead wait for `empty` before reading. All other behaviour is identical.

## Structure
- **Package `rf_wb_pkg`** holds:
  - `XLEN` and `AW` defaults.
  - The `rf_wb_entry_t` struct {rd, data}.
  - The `rf_wb_src_e` enum {SRC_ALU, SRC_LSU} used for `last_grant`.
- **Sub-module `rf_wb_fifo`** holds storage, pointers, count and a valid vector exposed for the bypass match. Arbitration and bypass live in `rf_wb_ctrl`.

## Test plan
- **Single write.** ALU {rd=5, 0xDEADBEEF} for one cycle → next cycle `io_rf_wen=1`, `io_rf_wa=5`, `io_rf_wd=0xDEADBEEF`; `pending` back to 0.
- **Conflict round-robin.** Both valid on 3 consecutive cycles with rd=1/2 → writes arrive in order LSU, ALU, LSU; the losing source sees `ready=0` for exactly those cycles.
- **Full under hold.** `wr_hold=1`, push 4 ALU results (rd=1..4) → `pending=4`, `alu_ready=0`.
  - Release `wr_hold` → rd=1..4 written on 4 consecutive cycles, then `empty=1`.
- **Bypass.** Hold FIFO holding rd=7 {0x11} then rd=7 {0x22}, `ra1=7`, `rf_rd1=0x0` → `rd1=0x22`. `ra2=8` → `rd2=rf_rd2`. Bypass disabled → `rd1=0x0`.
- **x0 discard.** LSU rd=0 data 0xFFFF → `lsu_ready=1`, `pending` stays 0, `io_rf_wen` never asserts.
- **Reset mid-operation.** `reset_n` low with `pending=3` → immediately `pending=0`, `io_rf_wen=0`; after release, no write occurs.
